core_pht: RTL and testbench



---
 rtl/core_bp_pkg.sv | 35 +++
 rtl/core_pht_ram.sv | 39 +++
 rtl/core_pht.sv | 164 ++++++++++++++++
 tb/tb_core_pht.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bp_pkg.sv
// -----------------------------------------------------------------------------
// core_bp_pkg
// Shared definitions for the branch-prediction blocks of the fetch stage.
//   - IDX_W_DEFAULT : default table index width (also the GHR width)
//   - CNT_SNT..ST   : 2-bit saturating counter encodings
//   - pht_state_e   : PHT controller states (INIT sweep, RUN)
//   - sat_next()    : next value of a 2-bit saturating counter
// -----------------------------------------------------------------------------
package core_bp_pkg;

  localparam int IDX_W_DEFAULT = 8;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_e;

  // Taken moves toward ST, not-taken toward SNT; both ends stick.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/core_pht_ram.sv
// -----------------------------------------------------------------------------
// core_pht_ram
// Storage array of 2-bit counters for the gshare PHT.
// Ports:
//   clk        in   rising-edge clock (write port)
//   rd_index   in   prediction read address (combinational read)
//   rd_data    out  counter at rd_index
//   upd_index  in   training read address (combinational read)
//   upd_data   out  counter at upd_index
//   we         in   write enable
//   wr_index   in   write address
//   wr_data    in   write data
// The array has no reset: the controller's init sweep defines its contents.
// Reads return the pre-edge value when a write hits the same entry.
// -----------------------------------------------------------------------------
module core_pht_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_index,
  output logic [1:0]       rd_data,
  input  logic [IDX_W-1:0] upd_index,
  output logic [1:0]       upd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [1:0]       wr_data
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_index] <= wr_data;
  end

  assign rd_data  = mem[rd_index];
  assign upd_data = mem[upd_index];

endmodule

// File: rtl/core_pht.sv
// -----------------------------------------------------------------------------
// core_pht
// Gshare pattern history table for the fetch stage. Predicts direction for the
// fetch PC (combinational, alongside the BTB lookup) using 2-bit counters
// indexed by pc[IDX_W+1:2] XOR a speculative global history register. Trains
// from resolved branches; recovers the GHR on a mispredict. After reset it
// sweeps every counter to CNT_INIT before predictions are enabled.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   pc, fetch_valid fetch PC and its qualifier
//   btb_v           BTB hit for pc (drives speculative GHR shift only)
//   PHT_pred_taken  prediction for pc (0 until the sweep completes)
//   pht_index_out   table index used for pc; carried with the branch
//   ghr_out         GHR before this fetch's shift; carried with the branch
//   pht_ready       sweep complete
//   update_*        training/recovery interface from execute
//   mispredict      qualified by update_pht; restores the GHR
// -----------------------------------------------------------------------------
module core_pht
  import core_bp_pkg::*;
#(
  parameter int         PHT_DEPTH = 256,
  parameter int         IDX_W     = IDX_W_DEFAULT,
  parameter logic [1:0] CNT_INIT  = CNT_WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             fetch_valid,
  input  logic             btb_v,
  output logic             PHT_pred_taken,
  output logic [IDX_W-1:0] pht_index_out,
  output logic [IDX_W-1:0] ghr_out,
  output logic             pht_ready,
  input  logic             update_pht,
  input  logic [IDX_W-1:0] update_index,
  input  logic             update_taken,
  input  logic [IDX_W-1:0] update_ghr,
  input  logic             mispredict
);

  localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(PHT_DEPTH - 1);

  pht_state_e       state_q;
  pht_state_e       state_d;
  logic [IDX_W-1:0] sweep_cnt;
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] fetch_index;
  logic [1:0]       pred_cnt;
  logic [1:0]       train_cnt;
  logic             in_init;
  logic             sweep_done;
  logic             pred_taken;
  logic             ram_we;
  logic [IDX_W-1:0] ram_wr_index;
  logic [1:0]       ram_wr_data;

  // Bits of pc and update_ghr that the hash/recovery never look at.
  logic unused_bits;
  assign unused_bits = ^{pc[31:IDX_W+2], pc[1:0], update_ghr[IDX_W-1]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // FSM: next state. The sweep leaves INIT on the edge that writes the last entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_init   = 1'b0;
    pht_ready = 1'b0;
    case (state_q)
      INIT:    in_init   = 1'b1;
      RUN:     pht_ready = 1'b1;
      default: in_init   = 1'b1;
    endcase
  end

  assign sweep_done = in_init && (sweep_cnt == SWEEP_LAST);

  // Sweep address; returns to 0 when the sweep finishes so a later reset
  // and the next sweep both start from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= '0;
    end else if (in_init) begin
      if (sweep_done) sweep_cnt <= '0;
      else            sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction path: pure function of pc and registered state. btb_v is not
  // involved, so there is no path from the BTB back into the prediction.
  // ---------------------------------------------------------------------------
  assign fetch_index    = pc[IDX_W+1:2] ^ ghr;
  assign pred_taken     = pht_ready && pred_cnt[1];
  assign PHT_pred_taken = pred_taken;
  assign pht_index_out  = fetch_index;
  assign ghr_out        = ghr;

  // ---------------------------------------------------------------------------
  // Single write port: the sweep owns it during INIT (training ignored);
  // afterwards resolved branches train the counter at update_index.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we       = 1'b0;
    ram_wr_index = '0;
    ram_wr_data  = CNT_INIT;
    if (in_init) begin
      ram_we       = 1'b1;
      ram_wr_index = sweep_cnt;
      ram_wr_data  = CNT_INIT;
    end else if (update_pht) begin
      ram_we       = 1'b1;
      ram_wr_index = update_index;
      ram_wr_data  = sat_next(train_cnt, update_taken);
    end
  end

  // ---------------------------------------------------------------------------
  // GHR: held at 0 through the sweep. In RUN a mispredict recovery rebuilds
  // history from the branch's own snapshot plus its real outcome, and wins
  // over any speculative shift in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (in_init) begin
      ghr <= '0;
    end else if (update_pht && mispredict) begin
      ghr <= {update_ghr[IDX_W-2:0], update_taken};
    end else if (fetch_valid && btb_v) begin
      ghr <= {ghr[IDX_W-2:0], pred_taken};
    end
  end

  core_pht_ram #(
    .DEPTH (PHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk       (clk),
    .rd_index  (fetch_index),
    .rd_data   (pred_cnt),
    .upd_index (update_index),
    .upd_data  (train_cnt),
    .we        (ram_we),
    .wr_index  (ram_wr_index),
    .wr_data   (ram_wr_data)
  );

endmodule

// File: tb/tb_core_pht.sv
// -----------------------------------------------------------------------------
// tb_core_pht
// Self-checking bench for core_pht: a table/history model driven from the
// sampled inputs at each rising edge, a negedge compare process against it,
// and directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_core_pht;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        fetch_valid = 1'b0;
  logic        btb_v = 1'b0;
  logic        PHT_pred_taken;
  logic [7:0]  pht_index_out;
  logic [7:0]  ghr_out;
  logic        pht_ready;
  logic        update_pht = 1'b0;
  logic [7:0]  update_index = '0;
  logic        update_taken = 1'b0;
  logic [7:0]  update_ghr = '0;
  logic        mispredict = 1'b0;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // Model state: counters as integers 0..3, history as an integer 0..255.
  int mtab [256];
  int mghr = 0;
  bit mready = 1'b0;
  int msweep = 0;

  core_pht dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .btb_v          (btb_v),
    .PHT_pred_taken (PHT_pred_taken),
    .pht_index_out  (pht_index_out),
    .ghr_out        (ghr_out),
    .pht_ready      (pht_ready),
    .update_pht     (update_pht),
    .update_index   (update_index),
    .update_taken   (update_taken),
    .update_ghr     (update_ghr),
    .mispredict     (mispredict)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int modelIndex();
    return int'((pc >> 2) & 32'hFF) ^ mghr;
  endfunction

  function automatic int modelPred();
    if (!mready) return 0;
    return (mtab[modelIndex()] >= 2) ? 1 : 0;
  endfunction

  // Model: sweep one entry per edge until all 256 are written; then train
  // counters and evolve history following the prediction rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mready = 1'b0;
      msweep = 0;
      mghr   = 0;
    end else if (!mready) begin
      mtab[msweep] = 1;
      msweep++;
      if (msweep == 256) mready = 1'b1;
    end else begin
      int p;
      int ui;
      p  = modelPred();
      ui = int'(update_index);
      if (update_pht) begin
        if (update_taken) mtab[ui] = (mtab[ui] < 3) ? mtab[ui] + 1 : 3;
        else              mtab[ui] = (mtab[ui] > 0) ? mtab[ui] - 1 : 0;
      end
      if (update_pht && mispredict)
        mghr = ((int'(update_ghr) * 2) + (update_taken ? 1 : 0)) % 256;
      else if (fetch_valid && btb_v)
        mghr = ((mghr * 2) + p) % 256;
    end
  end

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ready", int'(pht_ready), mready ? 1 : 0);
      checkOutput("pred", int'(PHT_pred_taken), modelPred());
      checkOutput("ghr", int'(ghr_out), mghr);
      checkOutput("index", int'(pht_index_out), modelIndex());
    end
  end

  task automatic applyStimulus(input logic [31:0] p, input logic fv, input logic bv,
                               input logic upd, input logic [7:0] idx, input logic tk,
                               input logic [7:0] ug, input logic mis);
    @(negedge clk);
    #2;
    pc = p; fetch_valid = fv; btb_v = bv;
    update_pht = upd; update_index = idx; update_taken = tk;
    update_ghr = ug; mispredict = mis;
  endtask

  task automatic idle();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Waits for pht_ready after reset release (edges counted from the first
  // edge with rst low), optionally throwing ignored traffic at the block.
  task automatic runSweep(input bit noisy, output int edges);
    edges = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      #1;
      edges = e;
      if (e == 255) checkOutput("ready_before_256", int'(pht_ready), 0);
      if (pht_ready) break;
      #1;
      if (noisy) begin
        pc = 32'(e * 4); fetch_valid = 1'b1; btb_v = 1'b1;
        update_pht = e[0]; update_index = 8'(e / 2); update_taken = e[1];
        update_ghr = 8'hFF; mispredict = 1'b1;
      end
    end
    checkOutput("sweep_edges", edges, 256);
  endtask

  // Each entry must hold exactly 01: one taken update makes it predict taken
  // (while the same-cycle read still sees 01), and a not-taken one restores it.
  task automatic tableCheck(input string name);
    int zero_a = 0;
    int one_b  = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(32'(i * 4), 1'b0, 1'b0, 1'b1, 8'(i), 1'b1, 8'h00, 1'b0);
      #2;
      if (!PHT_pred_taken) zero_a++;
      applyStimulus(32'(i * 4), 1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
      #2;
      if (PHT_pred_taken) one_b++;
    end
    checkOutput({name, "_old_read"}, zero_a, 256);
    checkOutput({name, "_all_01"}, one_b, 256);
  endtask

  initial begin
    int edges;
    #1;
    rst = 1'b1;
    pc  = 32'h0000_03C8;
    #1;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_ready", int'(pht_ready), 0);
    checkOutput("rst_pred", int'(PHT_pred_taken), 0);
    checkOutput("rst_ghr", int'(ghr_out), 0);
    checkOutput("rst_index", int'(pht_index_out), 32'hF2);

    // First sweep, with ignored updates/fetches/mispredicts throughout.
    rst = 1'b0;
    runSweep(1'b1, edges);
    idle();
    tableCheck("sweep1");

    // Saturation at index 0x05 with GHR 0.
    repeat (3) applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 1'b0);
    applyStimulus(32'h14, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2 checkOutput("sat_st_pred", int'(PHT_pred_taken), 1);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h14, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2 checkOutput("sat_hold_11", int'(PHT_pred_taken), 1);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h14, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2 checkOutput("sat_back_01", int'(PHT_pred_taken), 0);

    // Speculative shift: make index 5 weakly taken, then fetch it with a BTB hit.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 1'b0);
    applyStimulus(32'h14, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2;
    checkOutput("spec_ghr_before", int'(ghr_out), 0);
    checkOutput("spec_pred", int'(PHT_pred_taken), 1);
    idle();
    #2 checkOutput("spec_ghr_after", int'(ghr_out), 8'h01);

    // Recovery beats a concurrent speculative shift.
    applyStimulus(32'h14, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 8'h5A, 1'b1);
    idle();
    #2 checkOutput("recover_ghr", int'(ghr_out), 8'hB5);
    // Non-mispredicted update leaves history alone.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    idle();
    #2 checkOutput("train_no_ghr", int'(ghr_out), 8'hB5);

    // Back to GHR 0, index 5 back to 01, then same-index collision.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b1);
    idle();
    #2 checkOutput("recover_zero", int'(ghr_out), 0);
    applyStimulus(32'h14, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 1'b0);
    #2 checkOutput("collide_old", int'(PHT_pred_taken), 0);
    applyStimulus(32'h14, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2 checkOutput("collide_new", int'(PHT_pred_taken), 1);

    // History with a non-trivial GHR: shift in a few predictions.
    applyStimulus(32'h14, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h20, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h3FC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'hABC, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b1, 8'h00, 1'b0);
    idle();

    // Mid-sweep reset at entry 100.
    rst = 1'b1;
    #1;
    checkOutput("rst_now_ghr", int'(ghr_out), 0);
    #1 rst = 1'b0;
    idle();
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", int'(pht_ready), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    runSweep(1'b1, edges);
    idle();
    tableCheck("sweep2");

    repeat (3) idle();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
